// File: rtl/oet_sort_engine_pkg.sv
// Shared definitions for the odd-even transposition sort engine:
// state encoding, default sizes and the derived index width.
package oet_sort_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int N_DEF = 32;
    localparam int W_DEF = 8;
    localparam int IDX_W = $clog2(N_DEF);

endpackage

// File: rtl/oet_sort_engine_cmp_swap.sv
// Single compare-exchange cell of the transposition network.
// lo feeds the lower array index, hi feeds the higher one.
module cmp_swap
    import oet_sort_engine_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter bit DESCEND = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    // Strict compare so equal keys never move.
    assign swap = DESCEND ? (a < b) : (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/oet_sort_engine.sv
// Snapshot N words, sort with one odd-even transposition phase per
// clock, then stream the result over a valid/ready handshake.
module oet_sort_engine
    import oet_sort_engine_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter bit DESCEND = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [N*W-1:0]       in_data,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_last,
    output logic                 done
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N + 1);

    state_t         state;
    logic [PW-1:0]  phase;
    logic [W-1:0]   arr [N];
    logic [W-1:0]   ev  [N];
    logic [W-1:0]   od  [N];
    logic [IW-1:0]  nxt;

    assign nxt = out_index + IW'(1);

    genvar g;
    generate
        for (g = 0; g < N / 2; g++) begin : g_even
            cmp_swap #(.W(W), .DESCEND(DESCEND)) u_cs (
                .a  (arr[2*g]),
                .b  (arr[2*g+1]),
                .lo (ev[2*g]),
                .hi (ev[2*g+1])
            );
        end
        for (g = 0; g < N / 2 - 1; g++) begin : g_odd
            cmp_swap #(.W(W), .DESCEND(DESCEND)) u_cs (
                .a  (arr[2*g+1]),
                .b  (arr[2*g+2]),
                .lo (od[2*g+1]),
                .hi (od[2*g+2])
            );
        end
    endgenerate

    // End elements sit out every odd phase.
    assign od[0]   = arr[0];
    assign od[N-1] = arr[N-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase     <= '0;
            out_index <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                arr[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            arr[i] <= in_data[i*W +: W];
                        end
                        phase <= '0;
                        busy  <= 1'b1;
                        state <= SORT;
                    end
                end
                SORT: begin
                    // Phase count N marks the hand-off cycle into DRAIN.
                    if (phase == PW'(N)) begin
                        state     <= DRAIN;
                        out_index <= '0;
                        out_data  <= arr[0];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end else begin
                        arr   <= phase[0] ? od : ev;
                        phase <= phase + PW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_index <= nxt;
                            out_data  <= arr[nxt];
                            out_last  <= (nxt == IW'(N - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oet_sort_engine.sv
// Bench for oet_sort_engine: ascending and descending instances side
// by side, checked against a queue-sort reference model.
module tb_oet_sort_engine;

    localparam int N = 32;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic           busy_a, valid_a, last_a, done_a;
    logic [W-1:0]   data_a;
    logic [4:0]     index_a;
    logic           busy_d, valid_d, last_d, done_d;
    logic [W-1:0]   data_d;
    logic [4:0]     index_d;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    int cur [N];
    int exp_a [$];
    int exp_d [$];

    always #5 clk = ~clk;

    oet_sort_engine #(.N(N), .W(W), .DESCEND(1'b0)) dut_a (
        .clock     (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_data   (in_data),
        .busy      (busy_a),
        .out_valid (valid_a),
        .out_ready (out_ready),
        .out_data  (data_a),
        .out_index (index_a),
        .out_last  (last_a),
        .done      (done_a)
    );

    oet_sort_engine #(.N(N), .W(W), .DESCEND(1'b1)) dut_d (
        .clock     (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_data   (in_data),
        .busy      (busy_d),
        .out_valid (valid_d),
        .out_ready (out_ready),
        .out_data  (data_d),
        .out_index (index_d),
        .out_last  (last_d),
        .done      (done_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_model();
        exp_a = {};
        for (int i = 0; i < N; i++) begin
            exp_a.push_back(cur[i]);
            in_data[i*W +: W] = W'(cur[i]);
        end
        exp_d = exp_a;
        exp_a.sort();
        exp_d.rsort();
    endtask

    task automatic launch(input bit disturb);
        int lat;
        load_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy_a, 1);
        check("done_low_after_start", done_a, 0);
        lat = 0;
        while (!valid_a && lat < 200) begin
            if (disturb && lat == 5) begin
                start = 1'b1;
                in_data = ~in_data;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("first_valid_latency", lat, N + 1);
        check("desc_valid_aligned", valid_d, 1);
    endtask

    task automatic collect(input bit rnd_ready, input bit disturb);
        int idx;
        int cyc;
        bit v;
        bit r;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 3000) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (disturb && idx == 3) begin
                start = 1'b1;
                in_data = {N{8'h5A}};
            end else begin
                start = 1'b0;
            end
            v = valid_a;
            check("valid_in_drain", valid_a, 1);
            check("busy_in_drain", busy_a, 1);
            if (v) begin
                check("asc_data", data_a, exp_a[idx]);
                check("asc_index", index_a, idx);
                check("asc_last", last_a, idx == N - 1);
                check("desc_data", data_d, exp_d[idx]);
                check("desc_index", index_d, idx);
                check("desc_last", last_d, idx == N - 1);
            end
            r = out_ready;
            tick();
            if (v && r) idx++;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("handshake_count", idx, N);
        if (!rnd_ready) check("drain_cycles", cyc, N);
        check("done_pulse", done_a, 1);
        check("desc_done_pulse", done_d, 1);
        check("busy_after_done", busy_a, 0);
        check("valid_after_done", valid_a, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_index", index_a, 0);
        check("rst_last", last_a, 0);
        check("rst_done", done_a, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) cur[i] = N - 1 - i;
        launch(1'b0);
        collect(1'b0, 1'b0);

        // Starts while done is still high.
        for (int i = 0; i < N; i++) cur[i] = i;
        launch(1'b0);
        collect(1'b0, 1'b0);

        for (int i = 0; i < N; i++) cur[i] = 8'hA5;
        launch(1'b0);
        collect(1'b0, 1'b0);

        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0:       cur[i] = 8'h00;
                1:       cur[i] = 8'hFF;
                default: cur[i] = int'($urandom_range(0, 255));
            endcase
        end
        launch(1'b0);
        collect(1'b0, 1'b0);

        for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(0, 255));
        launch(1'b1);
        collect(1'b1, 1'b1);
        tick();
        check("done_one_cycle", done_a, 0);

        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("busy_mid_sort", busy_a, 1);
        reset_n = 1'b0;
        tick();
        check("midrst_busy", busy_a, 0);
        check("midrst_valid", valid_a, 0);
        check("midrst_data", data_a, 0);
        check("midrst_index", index_a, 0);
        check("midrst_last", last_a, 0);
        check("midrst_done", done_a, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(0, 255));
        launch(1'b0);
        collect(1'b1, 1'b0);
        tick();
        check("final_done_low", done_a, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
